// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler: word width, ALU opcodes,
// FSM state encoding and the illegal-opcode test.
package alu_pkg;
    localparam int WORD = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Opcodes 110 and 111 have no ALU meaning.
    function automatic logic op_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction
endpackage

// File: rtl/alu_sched_if.sv
// Requester and response channel bundle between issue logic and the ALU scheduler.
interface alu_sched_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
);
    import alu_pkg::*;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [WORD*NREQ-1:0] req_a;
    logic [WORD*NREQ-1:0] req_b;
    logic [3*NREQ-1:0]    req_op;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [WORD-1:0]      resp_c;
    logic                 resp_err;
    logic                 busy;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_c, resp_err, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_id, resp_c, resp_err, busy
    );
endinterface

// File: rtl/alu.sv
// Shared 32-bit six-operation ALU datapath, purely combinational.
module alu
    import alu_pkg::*;
(
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    input  logic [2:0]      op,
    output logic [WORD-1:0] c
);
    always_comb begin
        c = '0;
        case (op)
            ALU_ADD: c = a + b;
            ALU_SUB: c = a - b;
            ALU_AND: c = a & b;
            ALU_OR:  c = a | b;
            ALU_SRL: c = a >> b[4:0];
            ALU_SRA: c = $signed(a) >>> b[4:0];
            default: c = '0;
        endcase
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts just above the last grant and wraps to 0.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);
    logic found;

    // Two passes: indices above last have priority, then the wrap-around from 0.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (IDW'(i) > last)) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (IDW'(i) <= last)) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDW'(i);
            end
        end
    end
endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between NREQ requesters: grant, capture operands, execute,
// then hold the tagged result until the consumer takes it.
module alu_sched
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input logic        clk,
    input logic        reset,
    alu_sched_if.slave bus
);
    state_t          state;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  id_q;
    logic [NREQ-1:0] gnt;
    logic            grant_ok;
    logic            hs;
    logic [WORD-1:0] a_q;
    logic [WORD-1:0] b_q;
    logic [2:0]      op_q;
    logic [WORD-1:0] alu_c;
    logic            resp_valid_q;
    logic [WORD-1:0] resp_c_q;
    logic [IDW-1:0]  resp_id_q;
    logic            resp_err_q;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req  (bus.req_valid),
        .last (last_grant),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    alu u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .c  (alu_c)
    );

    // A new request may be taken when idle, or when the held result leaves this cycle.
    assign grant_ok      = (state == ST_IDLE) || ((state == ST_RESP) && bus.resp_ready);
    assign bus.req_ready = grant_ok ? gnt : '0;
    assign hs            = |bus.req_ready;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_c     = resp_c_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_err   = resp_err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            last_grant   <= IDW'(NREQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_c_q     <= '0;
            resp_id_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            if (hs) begin
                a_q        <= bus.req_a[WORD*int'(gnt_idx) +: WORD];
                b_q        <= bus.req_b[WORD*int'(gnt_idx) +: WORD];
                op_q       <= bus.req_op[3*int'(gnt_idx) +: 3];
                id_q       <= gnt_idx;
                last_grant <= gnt_idx;
            end
            case (state)
                ST_IDLE: if (hs) state <= ST_EXEC;
                ST_EXEC: begin
                    resp_c_q     <= op_illegal(op_q) ? '0 : alu_c;
                    resp_err_q   <= op_illegal(op_q);
                    resp_id_q    <= id_q;
                    resp_valid_q <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= hs ? ST_EXEC : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: a round-robin/timing model predicts grants and
// pushes expected results; a separate monitor pops them when responses appear.
module tb_alu_sched;
    import alu_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = 3;

    typedef struct {
        int          id;
        logic [31:0] c;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    rsp_t sb[$];
    rsp_t got[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    alu_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, output logic err);
        logic [31:0] ones;
        logic [31:0] r;
        int s;
        ones = '1;
        s    = int'(b % 32);
        err  = 1'b0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a >> s;
            3'd5: begin
                r = a >> s;
                if (a[31]) r = r | ~(ones >> s);
            end
            default: begin
                r   = 32'd0;
                err = 1'b1;
            end
        endcase
        return r;
    endfunction

    // Model: at most one op outstanding; its result is visible two negedges after
    // acceptance; a new op is accepted when nothing is outstanding or the visible
    // result is being consumed. Winner = first valid after the last winner.
    initial begin
        int          last_m;
        bit          pending;
        int          acc_cyc;
        bit          vis;
        bit          can;
        int          w;
        int          j;
        logic [NREQ-1:0] pred;
        rsp_t        e;
        last_m  = NREQ - 1;
        pending = 0;
        acc_cyc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pending = 0;
                last_m  = NREQ - 1;
                sb.delete();
            end else begin
                vis  = pending && (cyc >= acc_cyc + 2);
                can  = !pending || (vis && bus.resp_ready);
                pred = '0;
                w    = -1;
                if (can) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        j = (last_m + k) % NREQ;
                        if (w < 0 && bus.req_valid[j]) w = j;
                    end
                end
                if (w >= 0) pred[w] = 1'b1;
                chk("req_ready", 32'(bus.req_ready), 32'(pred));
                chk("busy", 32'(bus.busy), 32'(pending));
                chk("resp_valid", 32'(bus.resp_valid), 32'(vis));
                if (vis && bus.resp_ready) pending = 0;
                if (w >= 0) begin
                    pending = 1;
                    acc_cyc = cyc;
                    last_m  = w;
                    e.id    = w;
                    e.c     = ref_alu(bus.req_a[32*w +: 32], bus.req_b[32*w +: 32],
                                      bus.req_op[3*w +: 3], e.err);
                    sb.push_back(e);
                end
            end
        end
    end

    // Monitor: compare every presented response with the head of the scoreboard.
    initial begin
        rsp_t a;
        forever begin
            @(negedge clk);
            if (reset && bus.resp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected actual id=%0d c=%h expected no response",
                             bus.resp_id, bus.resp_c);
                end else begin
                    chk("resp_c", bus.resp_c, sb[0].c);
                    chk("resp_id", 32'(bus.resp_id), 32'(sb[0].id));
                    chk("resp_err", 32'(bus.resp_err), 32'(sb[0].err));
                    if (bus.resp_ready) begin
                        a.id  = int'(bus.resp_id);
                        a.c   = bus.resp_c;
                        a.err = bus.resp_err;
                        got.push_back(a);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        bus.req_op[3*i +: 3]  = op;
    endtask

    // Present one op on requester i, wait for its grant, then withdraw.
    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
        set_req(i, a, b, op);
        bus.req_valid[i] = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (bus.req_ready[i]) break;
        end
        if (!bus.req_ready[i]) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=no grant expected=grant for requester %0d", i);
        end
        step();
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_got(input int n);
        repeat (50) begin
            if (got.size() >= n) break;
            @(negedge clk);
        end
        chk("got_count", 32'(got.size()), 32'(n));
    endtask

    initial begin
        logic [31:0] exp6 [6];
        logic [31:0] c0;
        int          w0;
        int          pulses;
        int          n;

        exp6[0] = 32'hFE00005F; exp6[1] = 32'hFE00005B; exp6[2] = 32'h00000000;
        exp6[3] = 32'hFE00005F; exp6[4] = 32'h3F800017; exp6[5] = 32'hFF800017;

        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_op     = '0;
        bus.resp_ready = 1'b0;
        reset          = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_c", bus.resp_c, 32'd0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        step();
        reset          = 1'b1;
        bus.resp_ready = 1'b1;

        // All six legal ops on requester 0.
        for (int op = 0; op < 6; op++) issue(0, 32'hFE00005D, 32'd2, 3'(op));
        wait_got(6);
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            chk("op_table_c", got[k].c, exp6[k]);
            chk("op_table_id", 32'(got[k].id), 32'd0);
        end

        // Both requesters valid: grants alternate, starting after requester 0.
        step();
        got.delete();
        set_req(0, 32'd10, 32'd1, 3'd0);
        set_req(1, 32'd20, 32'd2, 3'd0);
        bus.req_valid = 2'b11;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (|bus.req_ready) n++;
            if (n == 4) break;
        end
        step();
        bus.req_valid = 2'b00;
        wait_got(4);
        if (got.size() >= 4) begin
            chk("alt_id0", 32'(got[0].id), 32'd1);
            chk("alt_id1", 32'(got[1].id), 32'd0);
            chk("alt_id2", 32'(got[2].id), 32'd1);
            chk("alt_id3", 32'(got[3].id), 32'd0);
            chk("alt_c0", got[0].c, 32'd22);
            chk("alt_c1", got[1].c, 32'd11);
        end

        // Backpressure: result held, no grants while resp_ready is low.
        step();
        got.delete();
        bus.resp_ready = 1'b0;
        bus.req_valid  = 2'b11;
        @(negedge clk);
        w0 = bus.req_ready[1] ? 1 : 0;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (|bus.req_ready) pulses++;
        end
        c0 = bus.resp_c;
        repeat (5) begin
            @(negedge clk);
            if (|bus.req_ready) pulses++;
            chk("hold_c", bus.resp_c, c0);
        end
        chk("hold_pulses", 32'(pulses), 32'd0);
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("release_grant", 32'(bus.req_ready), 32'(1 << (1 - w0)));
        step();
        bus.req_valid = 2'b00;
        wait_got(2);

        // Illegal op, then a legal one.
        step();
        got.delete();
        issue(0, 32'h12345678, 32'd1, 3'b110);
        issue(1, 32'd5, 32'd3, 3'b000);
        wait_got(2);
        if (got.size() >= 2) begin
            chk("illegal_c", got[0].c, 32'd0);
            chk("illegal_err", 32'(got[0].err), 32'd1);
            chk("legal_c", got[1].c, 32'd8);
            chk("legal_err", 32'(got[1].err), 32'd0);
        end

        // Reset while the op is in EXEC: discarded, outputs cleared, arbiter restarts at 0.
        step();
        got.delete();
        set_req(0, 32'd1, 32'd1, 3'd0);
        bus.req_valid[0] = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (bus.req_ready[0]) break;
        end
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_resp_c", bus.resp_c, 32'd0);
        chk("mid_rst_resp_id", 32'(bus.resp_id), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        step();
        reset = 1'b1;
        repeat (3) step();
        chk("mid_rst_no_resp", 32'(got.size()), 32'd0);
        set_req(1, 32'd7, 32'd7, 3'd0);
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("post_rst_grant", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 2'b00;
        wait_got(1);

        // Arithmetic boundaries.
        step();
        got.delete();
        issue(0, 32'hFFFFFFFF, 32'd1, 3'd0);
        issue(1, 32'h00000000, 32'd1, 3'd1);
        issue(0, 32'h80000000, 32'h3F, 3'd5);
        wait_got(3);
        if (got.size() >= 3) begin
            chk("wrap_add", got[0].c, 32'h00000000);
            chk("wrap_sub", got[1].c, 32'hFFFFFFFF);
            chk("sra_31", got[2].c, 32'hFFFFFFFF);
        end

        // Random traffic with random backpressure.
        step();
        repeat (400) begin
            bus.req_valid  = NREQ'($urandom_range(0, 3));
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                        3'($urandom_range(0, 7)));
            end
            step();
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        repeat (10) step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
